// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus bundle.
// Carries the ALU result input, the load result handshake, the register file write port,
// the decode busy-query pair and the load queue occupancy.
//   master : execute/memory/decode side (drives results and queries, observes writes)
//   slave  : the arbiter itself
interface writeback_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH = 2
);
    logic                          alu_valid;
    logic [ADDR_WIDTH-1:0]         alu_register;
    logic [DATA_WIDTH-1:0]         alu_data;
    logic                          load_valid;
    logic                          load_ready;
    logic [ADDR_WIDTH-1:0]         load_register;
    logic [DATA_WIDTH-1:0]         load_data;
    logic                          register_write;
    logic [ADDR_WIDTH-1:0]         write_register;
    logic [DATA_WIDTH-1:0]         write_data;
    logic [ADDR_WIDTH-1:0]         query_register_1;
    logic [ADDR_WIDTH-1:0]         query_register_2;
    logic                          query_busy_1;
    logic                          query_busy_2;
    logic [$clog2(FIFO_DEPTH):0]   pending_count;

    modport master (
        output alu_valid, alu_register, alu_data,
        output load_valid, load_register, load_data,
        output query_register_1, query_register_2,
        input  load_ready, register_write, write_register, write_data,
        input  query_busy_1, query_busy_2, pending_count
    );

    modport slave (
        input  alu_valid, alu_register, alu_data,
        input  load_valid, load_register, load_data,
        input  query_register_1, query_register_2,
        output load_ready, register_write, write_register, write_data,
        output query_busy_1, query_busy_2, pending_count
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Register file write-port arbiter.
// ALU results always take the write port; load results are queued in a small circular
// FIFO and retire in cycles where the ALU does not write. Decode can ask whether a
// register has a queued load pending via two combinational busy queries.
// Ports:
//   clk_i  : clock, all state updates on the rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : writeback_arbiter_if slave modport (results in, register file write out,
//            busy queries, pending load count)
module writeback_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    writeback_arbiter_if.slave bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_WIDTH-1:0] fifo_reg_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;

    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  alu_write;
    logic                  load_ready;
    logic                  push;
    logic                  pop;
    logic [FIFO_DEPTH-1:0] entry_valid;
    logic [PtrW-1:0]       offset;

    // Readiness comes from the registered count only, so a same-cycle pop never frees space.
    assign load_ready = rst_ni && (count_q < CntW'(FIFO_DEPTH));
    assign alu_write  = bus.alu_valid && (bus.alu_register != '0);
    assign push       = bus.load_valid && load_ready && (bus.load_register != '0);
    assign pop        = !alu_write && (count_q != '0);

    always_comb begin
        we_d     = 1'b0;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (alu_write) begin
            we_d    = 1'b1;
            wreg_d  = bus.alu_register;
            wdata_d = bus.alu_data;
        end else if (pop) begin
            we_d     = 1'b1;
            wreg_d   = fifo_reg_q[rd_ptr_q];
            wdata_d  = fifo_data_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        entry_valid = '0;
        offset      = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            offset         = PtrW'(i) - rd_ptr_q;
            entry_valid[i] = ({1'b0, offset} < count_q);
        end
    end

    always_comb begin
        bus.query_busy_1 = 1'b0;
        bus.query_busy_2 = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i] && (fifo_reg_q[i] == bus.query_register_1)
                && (bus.query_register_1 != '0)) begin
                bus.query_busy_1 = 1'b1;
            end
            if (entry_valid[i] && (fifo_reg_q[i] == bus.query_register_2)
                && (bus.query_register_2 != '0)) begin
                bus.query_busy_2 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_reg_q[i]  <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            if (push) begin
                fifo_reg_q[wr_ptr_q]  <= bus.load_register;
                fifo_data_q[wr_ptr_q] <= bus.load_data;
            end
        end
    end

    assign bus.load_ready     = load_ready;
    assign bus.register_write = we_q;
    assign bus.write_register = wreg_q;
    assign bus.write_data     = wdata_q;
    assign bus.pending_count  = count_q;
endmodule
